// File: rtl/wb_write_queue_if.sv
// -----------------------------------------------------------------------------
// wb_write_queue_if
//   Bundles every non-clock/reset signal of the writeback write queue.
//   master : the stage feeding the queue / observing its outputs
//   slave  : the queue itself
//   Signals:
//     EnqValid/EnqReady/EnqRW/EnqData : write request handshake
//     DrainEn                         : permits a pop this cycle
//     RW/BusW/RegWr                   : register file write port (registered)
//     RA/RB, FwdHitA/B, FwdDataA/B    : forwarding lookups
//     Count                           : number of occupied FIFO entries
// -----------------------------------------------------------------------------
interface wb_write_queue_if #(
  parameter int AW = 2
);
  logic        EnqValid;
  logic        EnqReady;
  logic [4:0]  EnqRW;
  logic [63:0] EnqData;
  logic        DrainEn;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic        FwdHitA;
  logic [63:0] FwdDataA;
  logic        FwdHitB;
  logic [63:0] FwdDataB;
  logic [AW:0] Count;

  modport master (
    output EnqValid, EnqRW, EnqData, DrainEn, RA, RB,
    input  EnqReady, RW, BusW, RegWr, FwdHitA, FwdDataA, FwdHitB, FwdDataB, Count
  );

  modport slave (
    input  EnqValid, EnqRW, EnqData, DrainEn, RA, RB,
    output EnqReady, RW, BusW, RegWr, FwdHitA, FwdDataA, FwdHitB, FwdDataB, Count
  );
endinterface

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//   Writeback buffer in front of the 64-bit x 32 register file. Queues
//   register-write requests, drains at most one per clock into the register
//   file write port, and forwards the youngest pending data for two read
//   addresses.
//   Ports:
//     Clk   : clock, all state updates on posedge
//     Reset : asynchronous, active-high reset
//     bus   : wb_write_queue_if.slave (handshake, write port, forwarding, Count)
//   Optional feature:
//     WB_BYPASS_EN : when defined, a non-XZR write accepted while the queue is
//                    empty and DrainEn=1 goes straight to the output stage.
// -----------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  wb_write_queue_if.slave bus
);

  localparam logic [4:0]  XZR      = 5'd31;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage
  logic [4:0]       ent_rw_q   [DEPTH];
  logic [63:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  // Output stage
  logic [4:0]  rw_q, rw_d;
  logic [63:0] busw_q, busw_d;
  logic        regwr_q, regwr_d;

  logic enq_fire;
  logic pop;
  logic bypass;
  logic store;

  // Full blocks new requests even if a pop happens this cycle.
  assign bus.EnqReady = (count_q < FULL_CNT);
  assign enq_fire     = bus.EnqValid && bus.EnqReady;
  // An entry written this edge is not yet counted, so it cannot be popped now.
  assign pop          = bus.DrainEn && (count_q != '0);

`ifdef WB_BYPASS_EN
  assign bypass = enq_fire && (bus.EnqRW != XZR) && (count_q == '0) && bus.DrainEn;
`else
  assign bypass = 1'b0;
`endif

  // XZR writes complete the handshake but are dropped.
  assign store = enq_fire && (bus.EnqRW != XZR) && !bypass;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    regwr_d = 1'b0;
    if (pop)   head_d = head_q + AW'(1);
    if (store) tail_d = tail_q + AW'(1);
    count_d = count_q + (AW+1)'(store) - (AW+1)'(pop);
    if (pop) begin
      rw_d    = ent_rw_q[head_q];
      busw_d  = ent_data_q[head_q];
      regwr_d = 1'b1;
    end else if (bypass) begin
      rw_d    = bus.EnqRW;
      busw_d  = bus.EnqData;
      regwr_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
      rw_q      <= '0;
      busw_q    <= '0;
      regwr_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      regwr_q <= regwr_d;
      // Push and pop never target the same slot: a pop needs count>0 and a
      // push needs count<DEPTH, so head != tail whenever both fire.
      if (store) ent_vld_q[tail_q] <= 1'b1;
      if (pop)   ent_vld_q[head_q] <= 1'b0;
    end
  end

  // NOTE: the payload array is deliberately not reset; the valid bits alone
  // decide whether an entry is visible, so stale payload is harmless.
  always_ff @(posedge Clk) begin
    if (store) begin
      ent_rw_q[tail_q]   <= bus.EnqRW;
      ent_data_q[tail_q] <= bus.EnqData;
    end
  end

  // Youngest match wins: start from the output stage (oldest), then walk the
  // FIFO from head towards tail, letting each later match override.
  function automatic logic [64:0] fwd_lookup(input logic [4:0] addr);
    logic          hit;
    logic [63:0]   data;
    logic [AW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    if (addr != XZR) begin
      if (regwr_q && (rw_q == addr)) begin
        hit  = 1'b1;
        data = busw_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + AW'(k);
        if (ent_vld_q[idx] && (ent_rw_q[idx] == addr)) begin
          hit  = 1'b1;
          data = ent_data_q[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  assign {bus.FwdHitA, bus.FwdDataA} = fwd_lookup(bus.RA);
  assign {bus.FwdHitB, bus.FwdDataB} = fwd_lookup(bus.RB);

  assign bus.RW    = rw_q;
  assign bus.BusW  = busw_q;
  assign bus.RegWr = regwr_q;
  assign bus.Count = count_q;

endmodule
